// File: rtl/turf_event_fragmenter.sv
// Cuts a raw 64-bit event stream into UDP fragments of at most nfrag+1 qwords.
// Each fragment is fully buffered, then sent as header beat, tag qword and payload.
module turf_event_fragmenter #(
    parameter int BUF_DEPTH     = 1024,
    parameter int BUF_ADDR_BITS = 10
) (
    input  logic        aclk,
    input  logic        areset,

    input  logic [63:0] s_event_tdata,
    input  logic [7:0]  s_event_tkeep,
    input  logic        s_event_tlast,
    input  logic        s_event_tvalid,
    output logic        s_event_tready,

    input  logic [9:0]  nfragment_count_i,
    input  logic [31:0] event_ip_i,
    input  logic [15:0] event_port_i,
    input  logic        event_open_i,

    output logic [63:0] m_udphdr_tdata,
    output logic        m_udphdr_tvalid,
    input  logic        m_udphdr_tready,

    output logic [63:0] m_udpdata_tdata,
    output logic [7:0]  m_udpdata_tkeep,
    output logic        m_udpdata_tlast,
    output logic        m_udpdata_tvalid,
    input  logic        m_udpdata_tready,

    output logic [31:0] event_count_o,
    output logic [31:0] drop_count_o,
    output logic [2:0]  fsm_state
);

    // All streams: a beat moves on a clock edge where tvalid && tready; tvalid is a
    // function of state only, and payload/keep/last hold steady until accepted.

    localparam int PTR_W = BUF_ADDR_BITS + 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FILL    = 3'd1,
        S_HEADER  = 3'd2,
        S_TAG     = 3'd3,
        S_PAYLOAD = 3'd4,
        S_DROP    = 3'd5
    } state_t;

    state_t state, state_nx;

    logic [31:0]              cfg_ip;
    logic [15:0]              cfg_port;
    logic [9:0]               cfg_nfrag;
    logic [15:0]              frag_index;
    logic [PTR_W-1:0]         wr_ptr;
    logic [PTR_W-1:0]         rd_ptr;
    logic [15:0]              byte_cnt;
    logic                     last_frag;
    logic [7:0]               last_keep;

    logic [63:0]              mem [BUF_DEPTH];
    logic [63:0]              rd_data;
    logic                     mem_we;
    logic                     mem_re;
    logic [BUF_ADDR_BITS-1:0] wr_addr;
    logic [BUF_ADDR_BITS-1:0] rd_addr;

    logic                     in_beat;
    logic                     frag_full;
    logic                     final_q;
    logic                     dat_acc;
    logic [15:0]              beat_bytes;
    logic [15:0]              udp_len;

    function automatic logic [3:0] popcnt8(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

    assign in_beat    = s_event_tvalid & s_event_tready;
    assign frag_full  = (wr_ptr == PTR_W'(cfg_nfrag));
    assign final_q    = (rd_ptr == wr_ptr - PTR_W'(1));
    assign dat_acc    = (state == S_PAYLOAD) & m_udpdata_tready;
    assign beat_bytes = s_event_tlast ? {12'b0, popcnt8(s_event_tkeep)} : 16'd8;
    assign udp_len    = byte_cnt + 16'd16;
    assign fsm_state  = state;

    // Registered-read buffer: rd_data holds while the payload beat is stalled.
    assign mem_we  = (state == S_FILL) & in_beat;
    assign wr_addr = wr_ptr[BUF_ADDR_BITS-1:0];
    assign mem_re  = (state == S_TAG) | dat_acc;
    assign rd_addr = (state == S_PAYLOAD) ? rd_ptr[BUF_ADDR_BITS-1:0] + BUF_ADDR_BITS'(1)
                                          : '0;

    always_ff @(posedge aclk) begin
        if (mem_we) begin
            mem[wr_addr] <= s_event_tdata;
        end
        if (mem_re) begin
            rd_data <= mem[rd_addr];
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx         = state;
        s_event_tready   = 1'b0;
        m_udphdr_tvalid  = 1'b0;
        m_udphdr_tdata   = '0;
        m_udpdata_tvalid = 1'b0;
        m_udpdata_tdata  = '0;
        m_udpdata_tkeep  = '0;
        m_udpdata_tlast  = 1'b0;
        case (state)
            S_IDLE: begin
                if (s_event_tvalid) begin
                    state_nx = event_open_i ? S_FILL : S_DROP;
                end
            end
            S_FILL: begin
                s_event_tready = 1'b1;
                if (s_event_tvalid && (s_event_tlast || frag_full)) begin
                    state_nx = S_HEADER;
                end
            end
            S_HEADER: begin
                m_udphdr_tvalid = 1'b1;
                m_udphdr_tdata  = {cfg_ip, cfg_port, udp_len};
                if (m_udphdr_tready) begin
                    state_nx = S_TAG;
                end
            end
            S_TAG: begin
                m_udpdata_tvalid = 1'b1;
                m_udpdata_tdata  = {event_count_o, frag_index, last_frag, byte_cnt[14:0]};
                m_udpdata_tkeep  = 8'hFF;
                if (m_udpdata_tready) begin
                    state_nx = S_PAYLOAD;
                end
            end
            S_PAYLOAD: begin
                m_udpdata_tvalid = 1'b1;
                m_udpdata_tdata  = rd_data;
                m_udpdata_tkeep  = final_q ? last_keep : 8'hFF;
                m_udpdata_tlast  = final_q;
                if (m_udpdata_tready && final_q) begin
                    state_nx = last_frag ? S_IDLE : S_FILL;
                end
            end
            S_DROP: begin
                s_event_tready = 1'b1;
                if (s_event_tvalid && s_event_tlast) begin
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            cfg_ip        <= '0;
            cfg_port      <= '0;
            cfg_nfrag     <= '0;
            frag_index    <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            byte_cnt      <= '0;
            last_frag     <= 1'b0;
            last_keep     <= '0;
            event_count_o <= '0;
            drop_count_o  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (s_event_tvalid) begin
                        cfg_ip     <= event_ip_i;
                        cfg_port   <= event_port_i;
                        cfg_nfrag  <= nfragment_count_i;
                        frag_index <= '0;
                        wr_ptr     <= '0;
                        byte_cnt   <= '0;
                    end
                end
                S_FILL: begin
                    if (in_beat) begin
                        wr_ptr    <= wr_ptr + PTR_W'(1);
                        byte_cnt  <= byte_cnt + beat_bytes;
                        last_keep <= s_event_tlast ? s_event_tkeep : 8'hFF;
                        if (s_event_tlast || frag_full) begin
                            last_frag <= s_event_tlast;
                        end
                    end
                end
                S_TAG: begin
                    rd_ptr <= '0;
                end
                S_PAYLOAD: begin
                    if (dat_acc) begin
                        rd_ptr <= rd_ptr + PTR_W'(1);
                        if (final_q) begin
                            if (last_frag) begin
                                event_count_o <= event_count_o + 32'd1;
                            end else begin
                                frag_index <= frag_index + 16'd1;
                                wr_ptr     <= '0;
                                byte_cnt   <= '0;
                            end
                        end
                    end
                end
                S_DROP: begin
                    if (in_beat && s_event_tlast) begin
                        drop_count_o <= drop_count_o + 32'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_turf_event_fragmenter.sv
// Randomized bench for turf_event_fragmenter: an event-level fragment model feeds
// expected header/data queues that a per-cycle compare process drains.
module tb_turf_event_fragmenter;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic [63:0] s_event_tdata;
  logic [7:0]  s_event_tkeep;
  logic        s_event_tlast;
  logic        s_event_tvalid;
  logic        s_event_tready;
  logic [9:0]  nfragment_count_i;
  logic [31:0] event_ip_i;
  logic [15:0] event_port_i;
  logic        event_open_i;
  logic [63:0] m_udphdr_tdata;
  logic        m_udphdr_tvalid;
  logic        m_udphdr_tready;
  logic [63:0] m_udpdata_tdata;
  logic [7:0]  m_udpdata_tkeep;
  logic        m_udpdata_tlast;
  logic        m_udpdata_tvalid;
  logic        m_udpdata_tready;
  logic [31:0] event_count_o;
  logic [31:0] drop_count_o;
  logic [2:0]  fsm_state;

  turf_event_fragmenter dut (
    .aclk              (aclk),
    .areset            (areset),
    .s_event_tdata     (s_event_tdata),
    .s_event_tkeep     (s_event_tkeep),
    .s_event_tlast     (s_event_tlast),
    .s_event_tvalid    (s_event_tvalid),
    .s_event_tready    (s_event_tready),
    .nfragment_count_i (nfragment_count_i),
    .event_ip_i        (event_ip_i),
    .event_port_i      (event_port_i),
    .event_open_i      (event_open_i),
    .m_udphdr_tdata    (m_udphdr_tdata),
    .m_udphdr_tvalid   (m_udphdr_tvalid),
    .m_udphdr_tready   (m_udphdr_tready),
    .m_udpdata_tdata   (m_udpdata_tdata),
    .m_udpdata_tkeep   (m_udpdata_tkeep),
    .m_udpdata_tlast   (m_udpdata_tlast),
    .m_udpdata_tvalid  (m_udpdata_tvalid),
    .m_udpdata_tready  (m_udpdata_tready),
    .event_count_o     (event_count_o),
    .drop_count_o      (drop_count_o),
    .fsm_state         (fsm_state)
  );

  // clock / reset
  always #5 aclk = ~aclk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  // scoreboard state
  int          checks = 0;
  int          fails = 0;
  logic [63:0] exp_hdr_q[$];
  logic [72:0] exp_dat_q[$];
  logic [63:0] ev_data[$];
  logic [15:0] obs_len_q[$];
  logic [63:0] obs_tag_q[$];
  logic [63:0] last_tag = '0;
  int          data_seen = 0;
  int          hdr_seen = 0;
  bit          expect_tag = 1'b0;
  bit          abort = 1'b0;
  bit          bp_mode = 1'b0;
  int          stalls = 0;
  int          exp_events = 0;
  int          exp_drops = 0;

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check73(input string name, input logic [72:0] act, input logic [72:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Event-level model: split into chunks of nfrag+1 qwords, one header/tag per chunk.
  function automatic void model_event(input int n, input int nfrag, input bit open,
                                      input logic [31:0] ip, input logic [15:0] port,
                                      input logic [7:0] lkeep);
    int fsz, nfr, start, len, bytes;
    bit is_last;
    if (!open) begin
      exp_drops++;
      return;
    end
    fsz = nfrag + 1;
    nfr = (n + fsz - 1) / fsz;
    for (int k = 0; k < nfr; k++) begin
      start   = k * fsz;
      len     = (n - start < fsz) ? n - start : fsz;
      is_last = (k == nfr - 1);
      bytes   = is_last ? 8 * (len - 1) + $countones(lkeep) : 8 * len;
      exp_hdr_q.push_back({ip, port, 16'(16 + bytes)});
      exp_dat_q.push_back({32'(exp_events), 16'(k), is_last, 15'(bytes), 8'hFF, 1'b0});
      for (int j = 0; j < len; j++) begin
        exp_dat_q.push_back({ev_data[start + j],
                             (j == len - 1 && is_last) ? lkeep : 8'hFF,
                             j == len - 1});
      end
    end
    exp_events++;
  endfunction

  // compare process
  logic [63:0] hdr_prev;
  logic [72:0] dat_prev;
  bit          hdr_hold = 1'b0;
  bit          dat_hold = 1'b0;

  always @(negedge aclk) begin
    if (areset) begin
      hdr_hold   = 1'b0;
      dat_hold   = 1'b0;
      expect_tag = 1'b0;
    end else begin
      if (m_udphdr_tvalid) begin
        if (hdr_hold) check64("hdr_stable", m_udphdr_tdata, hdr_prev);
        if (m_udphdr_tready) begin
          hdr_seen++;
          if (exp_hdr_q.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL hdr_unexpected: got %h expected no header", m_udphdr_tdata);
          end else begin
            check64("hdr_beat", m_udphdr_tdata, exp_hdr_q.pop_front());
          end
          obs_len_q.push_back(m_udphdr_tdata[15:0]);
          expect_tag = 1'b1;
          hdr_hold   = 1'b0;
        end else begin
          hdr_hold = 1'b1;
          hdr_prev = m_udphdr_tdata;
        end
      end else begin
        if (hdr_hold) check64("hdr_valid_held", 64'(m_udphdr_tvalid), 64'd1);
        hdr_hold = 1'b0;
      end

      if (m_udpdata_tvalid) begin
        if (dat_hold)
          check73("dat_stable", {m_udpdata_tdata, m_udpdata_tkeep, m_udpdata_tlast}, dat_prev);
        if (m_udpdata_tready) begin
          data_seen++;
          if (exp_dat_q.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL dat_unexpected: got %h expected no data", m_udpdata_tdata);
          end else begin
            check73("dat_beat", {m_udpdata_tdata, m_udpdata_tkeep, m_udpdata_tlast},
                    exp_dat_q.pop_front());
          end
          if (expect_tag) begin
            last_tag = m_udpdata_tdata;
            obs_tag_q.push_back(m_udpdata_tdata);
            expect_tag = 1'b0;
          end
          dat_hold = 1'b0;
        end else begin
          dat_hold = 1'b1;
          dat_prev = {m_udpdata_tdata, m_udpdata_tkeep, m_udpdata_tlast};
        end
      end else begin
        if (dat_hold) check64("dat_valid_held", 64'(m_udpdata_tvalid), 64'd1);
        dat_hold = 1'b0;
      end
    end
  end

  // sink ready driver
  initial begin
    m_udphdr_tready  = 1'b1;
    m_udpdata_tready = 1'b1;
    forever begin
      @(posedge aclk);
      #1;
      if (bp_mode) begin
        m_udphdr_tready  = 1'($urandom_range(0, 1));
        m_udpdata_tready = 1'($urandom_range(0, 1));
      end else begin
        m_udphdr_tready  = 1'b1;
        m_udpdata_tready = 1'b1;
      end
    end
  end

  // driver tasks
  task automatic gen_event(input int n);
    ev_data.delete();
    for (int i = 0; i < n; i++) ev_data.push_back({$urandom, $urandom});
  endtask

  task automatic send_event(input int n, input logic [7:0] lkeep, input int change_at,
                            input bit gaps);
    int w;
    stalls = 0;
    for (int i = 0; i < n; i++) begin
      s_event_tdata  = ev_data[i];
      s_event_tlast  = (i == n - 1);
      s_event_tkeep  = (i == n - 1) ? lkeep : 8'($urandom);
      s_event_tvalid = 1'b1;
      w = 0;
      forever begin
        @(negedge aclk);
        if (abort) begin
          s_event_tvalid = 1'b0;
          return;
        end
        if (s_event_tready) break;
        stalls++;
        w++;
        if (w > 5000) begin
          checks++;
          fails++;
          $display("FAIL in_timeout: got no s_event_tready at beat %0d expected acceptance", i);
          s_event_tvalid = 1'b0;
          return;
        end
      end
      @(posedge aclk);
      #1;
      s_event_tvalid = 1'b0;
      if (i == change_at) begin
        nfragment_count_i = 10'd7;
        event_open_i      = 1'b0;
      end
      if (gaps && $urandom_range(0, 3) == 0) begin
        @(posedge aclk);
        #1;
      end
    end
  endtask

  task automatic drain();
    int w = 0;
    while ((exp_hdr_q.size() != 0 || exp_dat_q.size() != 0) && w < 20000) begin
      @(posedge aclk);
      w++;
    end
    checks++;
    if (w >= 20000) begin
      fails++;
      $display("FAIL drain_timeout: got %0d hdr / %0d data pending expected 0",
               exp_hdr_q.size(), exp_dat_q.size());
    end
    repeat (3) @(posedge aclk);
    #1;
  endtask

  function automatic logic [15:0] len_at(input int i);
    return (i < obs_len_q.size()) ? obs_len_q[i] : 16'hFFFF;
  endfunction

  function automatic logic [63:0] tag_at(input int i);
    return (i < obs_tag_q.size()) ? obs_tag_q[i] : '1;
  endfunction

  logic [15:0] exp_len1[3] = '{16'd1040, 16'd1040, 16'd364};
  logic [63:0] exp_tag1[3] = '{64'h0000_0001_0000_0400, 64'h0000_0001_0001_0400,
                               64'h0000_0001_0002_815C};

  initial begin
    int hdr_before;
    int base;
    int n;
    int nf;
    bit op;
    logic [7:0] lk;

    s_event_tdata     = '0;
    s_event_tkeep     = '0;
    s_event_tlast     = 1'b0;
    s_event_tvalid    = 1'b0;
    nfragment_count_i = 10'd127;
    event_ip_i        = 32'hC0A8_0001;
    event_port_i      = 16'h1234;
    event_open_i      = 1'b1;

    // reset values
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    check64("rst_in_ready", 64'(s_event_tready), 64'd0);
    check64("rst_hdr_valid", 64'(m_udphdr_tvalid), 64'd0);
    check64("rst_dat_valid", 64'(m_udpdata_tvalid), 64'd0);
    check64("rst_dat_last_keep", {55'd0, m_udpdata_tlast, m_udpdata_tkeep}, 64'd0);
    check64("rst_hdr_data", m_udphdr_tdata, 64'd0);
    check64("rst_dat_data", m_udpdata_tdata, 64'd0);
    check64("rst_counts", {event_count_o, drop_count_o}, 64'd0);
    @(posedge aclk);
    #1;
    areset = 1'b0;
    repeat (2) @(posedge aclk);
    #1;

    // single-beat event
    nfragment_count_i = 10'd0;
    gen_event(1);
    model_event(1, 0, 1'b1, event_ip_i, event_port_i, 8'hFF);
    send_event(1, 8'hFF, -1, 1'b0);
    @(negedge aclk);
    check64("hdr_valid_after_close", 64'(m_udphdr_tvalid), 64'd1);
    drain();
    check64("single_len", {48'd0, len_at(0)}, 64'd24);
    check64("single_tag", last_tag, 64'h0000_0000_0000_8008);
    check64("single_evcnt", 64'(event_count_o), 64'd1);

    // multi-fragment event
    obs_len_q.delete();
    obs_tag_q.delete();
    nfragment_count_i = 10'd127;
    event_ip_i        = 32'h0A00_0042;
    event_port_i      = 16'hBEEF;
    gen_event(300);
    model_event(300, 127, 1'b1, event_ip_i, event_port_i, 8'h0F);
    send_event(300, 8'h0F, -1, 1'b1);
    drain();
    for (int i = 0; i < 3; i++) begin
      check64("multi_len", {48'd0, len_at(i)}, {48'd0, exp_len1[i]});
      check64("multi_tag", tag_at(i), exp_tag1[i]);
    end
    check64("multi_frag_count", 64'(obs_len_q.size()), 64'd3);
    check64("multi_evcnt", 64'(event_count_o), 64'd2);

    // closed path
    event_open_i = 1'b0;
    hdr_before   = hdr_seen;
    for (int e = 0; e < 2; e++) begin
      gen_event(5);
      model_event(5, 127, 1'b0, event_ip_i, event_port_i, 8'hFF);
      send_event(5, 8'hFF, -1, 1'b0);
      check64("drop_stalls", 64'(stalls), 64'd1);
    end
    drain();
    check64("drop_no_hdr", 64'(hdr_seen - hdr_before), 64'd0);
    check64("drop_count", 64'(drop_count_o), 64'd2);

    // back-pressure
    event_open_i      = 1'b1;
    nfragment_count_i = 10'd15;
    bp_mode           = 1'b1;
    gen_event(50);
    model_event(50, 15, 1'b1, event_ip_i, event_port_i, 8'h3F);
    send_event(50, 8'h3F, -1, 1'b1);
    drain();
    bp_mode = 1'b0;
    repeat (2) @(posedge aclk);
    #1;
    check64("bp_evcnt", 64'(event_count_o), 64'(exp_events));

    // mid-event configuration change
    obs_len_q.delete();
    nfragment_count_i = 10'd127;
    event_open_i      = 1'b1;
    gen_event(200);
    model_event(200, 127, 1'b1, event_ip_i, event_port_i, 8'hFF);
    send_event(200, 8'hFF, 9, 1'b0);
    drain();
    check64("cfg_len0", {48'd0, len_at(0)}, 64'd1040);
    check64("cfg_len1", {48'd0, len_at(1)}, 64'd592);
    gen_event(10);
    model_event(10, 7, 1'b0, event_ip_i, event_port_i, 8'hFF);
    send_event(10, 8'hFF, -1, 1'b0);
    drain();
    check64("cfg_next_dropped", 64'(drop_count_o), 64'd3);

    // reset during payload of fragment 1
    event_open_i      = 1'b1;
    nfragment_count_i = 10'd127;
    gen_event(300);
    model_event(300, 127, 1'b1, event_ip_i, event_port_i, 8'hFF);
    base = data_seen;
    fork
      send_event(300, 8'hFF, -1, 1'b0);
      begin
        int w = 0;
        while (data_seen < base + 135 && w < 5000) begin
          @(negedge aclk);
          w++;
        end
        checks++;
        if (w >= 5000) begin
          fails++;
          $display("FAIL rst_wait: got %0d data beats expected %0d", data_seen - base, 135);
        end
        @(negedge aclk);
        #2;
        areset = 1'b1;
        #1;
        check64("arst_in_ready", 64'(s_event_tready), 64'd0);
        check64("arst_hdr_valid", 64'(m_udphdr_tvalid), 64'd0);
        check64("arst_dat_valid", 64'(m_udpdata_tvalid), 64'd0);
        check64("arst_dat_last_keep", {55'd0, m_udpdata_tlast, m_udpdata_tkeep}, 64'd0);
        check64("arst_dat_data", m_udpdata_tdata, 64'd0);
        check64("arst_counts", {event_count_o, drop_count_o}, 64'd0);
        abort = 1'b1;
        s_event_tvalid = 1'b0;
        exp_hdr_q.delete();
        exp_dat_q.delete();
        exp_events = 0;
        exp_drops  = 0;
        repeat (2) @(posedge aclk);
        #1;
        areset = 1'b0;
      end
    join
    abort = 1'b0;
    repeat (2) @(posedge aclk);
    #1;
    nfragment_count_i = 10'd7;
    gen_event(3);
    model_event(3, 7, 1'b1, event_ip_i, event_port_i, 8'hFF);
    send_event(3, 8'hFF, -1, 1'b0);
    drain();
    check64("post_rst_tag", last_tag, 64'h0000_0000_0000_8018);
    check64("post_rst_evcnt", 64'(event_count_o), 64'd1);

    // randomized events
    for (int e = 0; e < 8; e++) begin
      n  = $urandom_range(1, 40);
      nf = $urandom_range(0, 15);
      op = ($urandom_range(0, 3) != 0);
      lk = 8'($urandom_range(1, 255));
      bp_mode           = 1'($urandom_range(0, 1));
      nfragment_count_i = 10'(nf);
      event_open_i      = op;
      event_ip_i        = $urandom;
      event_port_i      = 16'($urandom);
      gen_event(n);
      model_event(n, nf, op, event_ip_i, event_port_i, lk);
      send_event(n, lk, -1, 1'b1);
      drain();
    end
    bp_mode = 1'b0;
    repeat (2) @(posedge aclk);
    #1;
    check64("final_evcnt", 64'(event_count_o), 64'(exp_events));
    check64("final_dropcnt", 64'(drop_count_o), 64'(exp_drops));

    $display("[TB] %0d tests run, %0d failed", checks, fails);
    $finish;
  end

endmodule

// File: doc/turf_event_fragmenter.md
# turf_event_fragmenter

Sits directly downstream of the TURF event control UDP port. It consumes that port's event-destination and fragment-size outputs, together with a raw 64-bit event data stream. Each event is cut into UDP fragments of at most `nfragment_count+1` data qwords, and each fragment is emitted as a UDP header beat plus a payload stream towards the UDP transmit mux. A fragment is fully buffered before its header is sent, because the UDP length field must be known up front.

## Interface

**Parameters**
- `BUF_DEPTH`, default 1024: fragment buffer depth in qwords. Must be ≥ `nfragment_count+1`, maximum 1024.
- `BUF_ADDR_BITS`, default 10: log2 of `BUF_DEPTH`.

**Ports**
- `aclk` in 1: the single clock.
- `areset` in 1: reset, asynchronous and active-high.
- `s_event_tdata` in 64, `s_event_tkeep` in 8, `s_event_tlast` in 1, `s_event_tvalid` in 1, `s_event_tready` out 1: event data stream; `tlast` marks the end of the event.
- `nfragment_count_i` in 10: data qwords per fragment, minus 1.
- `event_ip_i` in 32: destination IP.
- `event_port_i` in 16: destination port.
- `event_open_i` in 1: event path enabled.
- `m_udphdr_tdata` out 64, `m_udphdr_tvalid` out 1, `m_udphdr_tready` in 1: header beat `{ip[63:32], port[31:16], udp_length[15:0]}`.
- `m_udpdata_tdata` out 64, `m_udpdata_tkeep` out 8, `m_udpdata_tlast` out 1, `m_udpdata_tvalid` out 1, `m_udpdata_tready` in 1: UDP payload stream.
- `event_count_o` out 32: number of events fully transmitted.
- `drop_count_o` out 32: number of events discarded while closed.

## Operation

**State machine:** IDLE, FILL, HEADER, TAG, PAYLOAD, DROP.

- **IDLE:** `s_event_tready` = 0.
  - On `s_event_tvalid`, latch `event_ip_i`, `event_port_i` and `nfragment_count_i` into `cfg_*`. These stay fixed for the whole event; mid-event changes on the inputs are ignored.
  - Clear `frag_index`.
  - Go to FILL if `event_open_i` = 1, else to DROP.
- **FILL:** `s_event_tready` = 1.
  - Each accepted beat is written to `buf[wr_ptr]` and `wr_ptr` increments.
  - `byte_cnt` accumulates 8 for a non-last beat, or popcount(`tkeep`) for the `tlast` beat. `tkeep` on non-last beats is ignored and treated as 8'hFF.
  - The fragment closes when `tlast` is accepted, or when `wr_ptr` reaches `cfg_nfrag+1`. Then go to HEADER with `last_frag` = `tlast`.
- **HEADER:** `m_udphdr_tvalid` = 1.
  - `udp_length` = 16 + `byte_cnt`, covering the 8-byte UDP header plus the 8-byte tag.
  - On `m_udphdr_tready`, go to TAG.
- **TAG:** `m_udpdata_tvalid` = 1, `tkeep` = FF, `tlast` = 0.
  - `tdata` = `{event_count_o[63:32], frag_index[31:16], last_frag[15], byte_cnt[14:0]}`.
  - On `tready`, go to PAYLOAD.
- **PAYLOAD:** streams `buf[0 .. wr_ptr-1]`.
  - `tkeep` = FF except on the final qword, which carries the latched final `tkeep`.
  - `tlast` is asserted on the final qword.
  - When the final qword is accepted:
    - If `last_frag`: increment `event_count_o` and go to IDLE.
    - Otherwise: increment `frag_index` (16-bit, wraps), clear `wr_ptr` and `byte_cnt`, and go to FILL.
- **DROP:** `s_event_tready` = 1. On accepting `tlast`, increment `drop_count_o` and go to IDLE.

**Boundary conditions**
- An event that ends exactly on a fragment boundary (for example 128 qwords with `nfrag` = 127) produces one fragment with `last_frag` = 1. There is no empty trailing fragment.
- A single-beat event produces a fragment with 1 data qword.
- `event_open_i` falling mid-event does not abort the event. It takes effect at the next IDLE.
- Both counters wrap at 2^32.
- Asserting `areset` at any point:
  - sends the FSM to IDLE and discards the partial fragment;
  - zeroes both counters and all `cfg` registers;
  - immediately deasserts all `tvalid` and `tready` outputs.

## Timing

**Reset values:**
- `s_event_tready` = 0
- `m_udphdr_tvalid` = 0
- `m_udpdata_tvalid` = 0
- `m_udpdata_tlast` = 0
- `m_udpdata_tkeep` = 0
- `m_udphdr_tdata` = 0
- `m_udpdata_tdata` = 0
- `event_count_o` = 0
- `drop_count_o` = 0

**Latency and throughput:**
- The buffer is a BRAM with a registered read. The implementation prefetches `buf[0]` during TAG.
- PAYLOAD sustains 1 qword per cycle while `tready` is held high. No bubbles are permitted after TAG.
- From IDLE, the first `s_event` beat is accepted on the cycle after `tvalid` is seen (IDLE→FILL takes 1 cycle).
- `m_udphdr_tvalid` rises the cycle after the closing beat is accepted.

**Handshake rules:**
- AXI4-Stream rules apply. Once `tvalid` is asserted, `tdata`, `tkeep` and `tlast` stay stable until `tready`.
- `tvalid` never depends combinationally on `tready`.
- The input stream stalls (`tready` = 0) during HEADER, TAG and PAYLOAD.

## Test plan

1. **Multi-fragment event:** `open` = 1, `nfrag` = 127, a 300-qword event with last `tkeep` = 0x0F.
   - Expect 3 fragments of 128, 128 and 44 data qwords.
   - UDP lengths 1040, 1040 and 364.
   - Tags: index 0, 1, 2; last flag only on index 2; byte fields 1024, 1024 and 348.
   - `event_count_o` = 1.
2. **Closed path:** `open` = 0, two events of 5 qwords each.
   - No `m_udphdr_tvalid` ever asserted.
   - `drop_count_o` = 2 and `s_event_tready` = 1 throughout both events.
3. **Single-beat event:** `nfrag` = 0, one event of 1 beat with `tkeep` = FF.
   - One fragment, `udp_length` = 24.
   - Tag = `{0, 0, 1, 8}`, payload of 1 qword with `tlast`.
4. **Back-pressure:** `m_udpdata_tready` toggled 1/0 at random during payload.
   - Data order and `tlast` position are unchanged.
   - `tdata` is held stable across every stall.
5. **Mid-event configuration change:** `nfrag` changed from 127 to 7 and `open` dropped after beat 10 of a 200-qword event.
   - The event still completes as 128 + 72 qwords.
   - The next event is dropped.
6. **Reset mid-operation:** `areset` pulsed during PAYLOAD of fragment 1.
   - Outputs go to 0 asynchronously and counters read 0.
   - The next event restarts at `frag_index` 0 with `event_count` 0 in its tag.
